// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display path.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package display_pkg;
  localparam int         NUM_DIGITS = 8;
  localparam logic [7:0] AN_OFF     = 8'hFF;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  typedef logic [NUM_DIGITS-1:0][6:0] seg_vec_t;
endpackage

// File: rtl/hex_to_seg.sv
// Nibble to active-low 7-segment pattern; blank forces all segments off.
module hex_to_seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'h0: seg = SEG_0;
        4'h1: seg = SEG_1;
        4'h2: seg = SEG_2;
        4'h3: seg = SEG_3;
        4'h4: seg = SEG_4;
        4'h5: seg = SEG_5;
        4'h6: seg = SEG_6;
        4'h7: seg = SEG_7;
        4'h8: seg = SEG_8;
        4'h9: seg = SEG_9;
        4'hA: seg = SEG_A;
        4'hB: seg = SEG_B;
        4'hC: seg = SEG_C;
        4'hD: seg = SEG_D;
        4'hE: seg = SEG_E;
        4'hF: seg = SEG_F;
        default: seg = SEG_BLANK;
      endcase
    end
  end
endmodule

// File: rtl/hex_word_display.sv
// 8-digit scanning hex display of a 32-bit word, captured only at frame ends so
// the display never tears; dp on digit 0 flashes for a few frames after a change.
module hex_word_display
  import display_pkg::*;
#(
  parameter int P_SCAN_DIV     = 100000,
  parameter int P_FLASH_FRAMES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_word,
  input  logic        i_freeze,
  input  logic        i_blank_lz,
  output logic [7:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic        o_frame_done,
  output logic        o_update
);
  localparam int               DIV_W   = $clog2(P_SCAN_DIV);
  localparam int               FL_W    = $clog2(P_FLASH_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(P_SCAN_DIV - 1);
  localparam logic [FL_W-1:0]  FL_LOAD = FL_W'(P_FLASH_FRAMES);

  logic [DIV_W-1:0]      r_div;
  logic [2:0]            r_idx;
  logic [31:0]           r_shadow;
  logic [FL_W-1:0]       r_flash;
  logic                  tick, frame_end, capture, changed;
  logic [NUM_DIGITS-1:0] lz;
  seg_vec_t              dig_seg;

  assign tick      = (r_div == DIV_MAX);
  assign frame_end = tick && (r_idx == 3'd7);
  assign capture   = frame_end && !i_freeze;
  assign changed   = capture && (i_word != r_shadow);

  // Digit 0 is never blanked so a zero word still shows one "0".
  assign lz[0] = 1'b0;
  for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_lz
    assign lz[k] = i_blank_lz && ((r_shadow >> (4 * k)) == 32'd0);
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    hex_to_seg u_seg (
      .nibble (r_shadow[4*k +: 4]),
      .blank  (lz[k]),
      .seg    (dig_seg[k])
    );
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div    <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_flash  <= '0;
    end else begin
      r_div <= tick ? '0 : r_div + 1'b1;
      if (tick)    r_idx    <= r_idx + 3'd1;
      if (capture) r_shadow <= i_word;
      if (changed)                              r_flash <= FL_LOAD;
      else if (frame_end && (r_flash != '0))    r_flash <= r_flash - 1'b1;
    end
  end

  // Anodes stay off for the first cycle of each slot to suppress ghosting.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_an         <= AN_OFF;
      o_seg        <= SEG_BLANK;
      o_dp         <= 1'b1;
      o_frame_done <= 1'b0;
      o_update     <= 1'b0;
    end else begin
      o_an         <= (r_div == '0) ? AN_OFF : ~(8'h01 << r_idx);
      o_seg        <= dig_seg[r_idx];
      o_dp         <= !((r_idx == 3'd0) && (r_flash != '0));
      o_frame_done <= frame_end;
      o_update     <= changed;
    end
  end
endmodule

// File: tb/tb_hex_word_display.sv
// Directed bench for hex_word_display with a 4-cycle slot and 2-frame flash.
module tb_hex_word_display;
  localparam int DIV   = 4;
  localparam int FLASH = 2;
  localparam int FRAME = 8 * DIV;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_word = 32'h0;
  logic        i_freeze = 1'b0;
  logic        i_blank_lz = 1'b0;
  logic [7:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp, o_frame_done, o_update;

  int n_checks = 0;
  int n_fail   = 0;

  hex_word_display #(.P_SCAN_DIV(DIV), .P_FLASH_FRAMES(FLASH)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_word       (i_word),
    .i_freeze     (i_freeze),
    .i_blank_lz   (i_blank_lz),
    .o_an         (o_an),
    .o_seg        (o_seg),
    .o_dp         (o_dp),
    .o_frame_done (o_frame_done),
    .o_update     (o_update)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #60000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Edge j of a frame: first edge of each slot is all-off, then anode j/DIV low.
  function automatic logic [7:0] an_at(int j);
    return (j % DIV == 0) ? 8'hFF : ~(8'h01 << (j / DIV));
  endfunction

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) step();
    n_checks++; if (o_an !== 8'hFF) begin n_fail++; $display("FAIL reset_an: got %h want ff", o_an); end
    n_checks++; if (o_seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %h want 7f", o_seg); end
    n_checks++; if (o_dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b want 1", o_dp); end
    n_checks++; if (o_frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", o_frame_done); end
    n_checks++; if (o_update !== 1'b0) begin n_fail++; $display("FAIL reset_update: got %b want 0", o_update); end
    i_rst = 1'b0;
  endtask

  task automatic test_scan_order();
    i_word = 32'h0; i_blank_lz = 1'b0; i_freeze = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int j = 0; j < FRAME; j++) begin
        step();
        n_checks++; if (o_an !== an_at(j)) begin n_fail++; $display("FAIL scan_an f%0d j%0d: got %h want %h", f, j, o_an, an_at(j)); end
        n_checks++; if (o_seg !== 7'h40) begin n_fail++; $display("FAIL scan_seg f%0d j%0d: got %h want 40", f, j, o_seg); end
        n_checks++; if (o_frame_done !== (j == FRAME - 1)) begin n_fail++; $display("FAIL scan_frame_done f%0d j%0d: got %b", f, j, o_frame_done); end
        n_checks++; if (o_dp !== 1'b1) begin n_fail++; $display("FAIL scan_dp f%0d j%0d: got %b want 1", f, j, o_dp); end
        n_checks++; if (o_update !== 1'b0) begin n_fail++; $display("FAIL scan_update f%0d j%0d: got %b want 0", f, j, o_update); end
      end
    end
  endtask

  task automatic test_capture();
    logic [6:0] want [8];
    logic       want_dp;
    int         n_upd;
    want = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
    n_upd = 0;
    i_word = 32'h1234ABCD;
    for (int f = 0; f < 4; f++) begin
      for (int j = 0; j < FRAME; j++) begin
        step();
        if (o_update) n_upd++;
        want_dp = !((f == 1 || f == 2) && j < DIV);
        if (f == 0) begin
          n_checks++; if (o_seg !== 7'h40) begin n_fail++; $display("FAIL capture_old_seg j%0d: got %h want 40", j, o_seg); end
          n_checks++; if (o_update !== (j == FRAME - 1)) begin n_fail++; $display("FAIL capture_update j%0d: got %b", j, o_update); end
        end else begin
          n_checks++; if (o_seg !== want[j / DIV]) begin n_fail++; $display("FAIL capture_seg f%0d j%0d: got %h want %h", f, j, o_seg, want[j / DIV]); end
        end
        n_checks++; if (o_dp !== want_dp) begin n_fail++; $display("FAIL capture_dp f%0d j%0d: got %b want %b", f, j, o_dp, want_dp); end
      end
    end
    n_checks++; if (n_upd != 1) begin n_fail++; $display("FAIL capture_update_count: got %0d want 1", n_upd); end
  endtask

  task automatic test_blank_lz();
    logic [6:0] want_f0 [8];
    logic [6:0] want_z [8];
    want_f0 = '{7'h40, 7'h0E, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    want_z  = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    i_blank_lz = 1'b1;
    i_word = 32'h000000F0;
    for (int j = 0; j < FRAME; j++) begin
      step();
      n_checks++; if (o_update !== (j == FRAME - 1)) begin n_fail++; $display("FAIL blank_update j%0d: got %b", j, o_update); end
    end
    i_word = 32'h0;
    for (int j = 0; j < FRAME; j++) begin
      step();
      n_checks++; if (o_seg !== want_f0[j / DIV]) begin n_fail++; $display("FAIL blank_f0_seg j%0d: got %h want %h", j, o_seg, want_f0[j / DIV]); end
    end
    for (int j = 0; j < FRAME; j++) begin
      step();
      n_checks++; if (o_seg !== want_z[j / DIV]) begin n_fail++; $display("FAIL blank_zero_seg j%0d: got %h want %h", j, o_seg, want_z[j / DIV]); end
      n_checks++; if (o_an !== an_at(j)) begin n_fail++; $display("FAIL blank_an j%0d: got %h want %h", j, o_an, an_at(j)); end
    end
  endtask

  task automatic test_freeze();
    logic [6:0] want1 [8];
    logic [6:0] want2 [8];
    want1 = '{7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    want2 = '{7'h24, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    i_blank_lz = 1'b0;
    i_word = 32'h1;
    for (int j = 0; j < FRAME; j++) begin
      step();
      n_checks++; if (o_seg !== 7'h40) begin n_fail++; $display("FAIL freeze_pre_seg j%0d: got %h want 40", j, o_seg); end
      n_checks++; if (o_update !== (j == FRAME - 1)) begin n_fail++; $display("FAIL freeze_pre_update j%0d: got %b", j, o_update); end
    end
    i_freeze = 1'b1;
    i_word = 32'h2;
    for (int f = 0; f < 2; f++) begin
      for (int j = 0; j < FRAME; j++) begin
        step();
        n_checks++; if (o_seg !== want1[j / DIV]) begin n_fail++; $display("FAIL freeze_hold_seg f%0d j%0d: got %h want %h", f, j, o_seg, want1[j / DIV]); end
        n_checks++; if (o_update !== (f == 1 && j == FRAME - 1)) begin n_fail++; $display("FAIL freeze_update f%0d j%0d: got %b", f, j, o_update); end
        // Release just before the frame-end edge: capture must happen on that edge.
        if (f == 1 && j == FRAME - 2) i_freeze = 1'b0;
      end
    end
    for (int j = 0; j < FRAME; j++) begin
      step();
      n_checks++; if (o_seg !== want2[j / DIV]) begin n_fail++; $display("FAIL freeze_release_seg j%0d: got %h want %h", j, o_seg, want2[j / DIV]); end
      n_checks++; if (o_update !== 1'b0) begin n_fail++; $display("FAIL freeze_release_update j%0d: got %b want 0", j, o_update); end
    end
  endtask

  task automatic test_no_tear();
    logic [6:0] want2 [8];
    logic [6:0] want5 [8];
    want2 = '{7'h24, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    want5 = '{7'h12, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    for (int j = 0; j < FRAME; j++) begin
      step();
      n_checks++; if (o_seg !== want2[j / DIV]) begin n_fail++; $display("FAIL notear_old_seg j%0d: got %h want %h", j, o_seg, want2[j / DIV]); end
      n_checks++; if (o_update !== (j == FRAME - 1)) begin n_fail++; $display("FAIL notear_update j%0d: got %b", j, o_update); end
      if (j == 12) i_word = 32'h5;
    end
    for (int j = 0; j < FRAME; j++) begin
      step();
      n_checks++; if (o_seg !== want5[j / DIV]) begin n_fail++; $display("FAIL notear_new_seg j%0d: got %h want %h", j, o_seg, want5[j / DIV]); end
    end
  endtask

  task automatic test_async_reset();
    i_word = 32'h3;
    repeat (FRAME) step();
    repeat (3) step();
    n_checks++; if (o_dp !== 1'b0) begin n_fail++; $display("FAIL areset_pre_dp: got %b want 0", o_dp); end
    #2 i_rst = 1'b1;
    #1;
    n_checks++; if (o_an !== 8'hFF) begin n_fail++; $display("FAIL areset_an: got %h want ff", o_an); end
    n_checks++; if (o_seg !== 7'h7F) begin n_fail++; $display("FAIL areset_seg: got %h want 7f", o_seg); end
    n_checks++; if (o_dp !== 1'b1) begin n_fail++; $display("FAIL areset_dp: got %b want 1", o_dp); end
    repeat (2) step();
    i_rst = 1'b0;
    for (int j = 0; j < FRAME; j++) begin
      step();
      n_checks++; if (o_an !== an_at(j)) begin n_fail++; $display("FAIL areset_post_an j%0d: got %h want %h", j, o_an, an_at(j)); end
      n_checks++; if (o_seg !== 7'h40) begin n_fail++; $display("FAIL areset_post_seg j%0d: got %h want 40", j, o_seg); end
      n_checks++; if (o_dp !== 1'b1) begin n_fail++; $display("FAIL areset_post_dp j%0d: got %b want 1", j, o_dp); end
      n_checks++; if (o_update !== (j == FRAME - 1)) begin n_fail++; $display("FAIL areset_post_update j%0d: got %b", j, o_update); end
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_capture();
    test_blank_lz();
    test_freeze();
    test_no_tear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
